// File: rtl/dlx_mem_arbiter.sv
// Purpose: shares one single-port memory between instruction fetch (IF) and data memory (DM).
// Latency: req to valid is 2 cycles minimum (grant edge, then ack edge); memory latency is set by mem_ack.
// Backpressure: requesters hold req while stalled; one transaction is outstanding; a missing ack aborts after TIMEOUT cycles.
module dlx_mem_arbiter #(
  parameter int AW         = 32,
  parameter int STARVE_MAX = 2,   // must be >= 1
  parameter int TIMEOUT    = 15   // must be >= 1
) (
  input  logic          clock1,
  input  logic          reset1,
  // instruction fetch side
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic [31:0]   if_rdata,
  output logic          if_valid,
  output logic          if_stall,
  // data memory side
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [31:0]   dm_wdata,
  output logic [31:0]   dm_rdata,
  output logic          dm_valid,
  output logic          dm_stall,
  // shared memory side
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ack,
  output logic          err
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] starve_cnt, starve_nxt;
  logic [TW-1:0] to_cnt, to_nxt;
  logic [TW-1:0] to_inc;
  logic          flush_pend, flush_pend_nxt;

  logic          mem_req_nxt, mem_we_nxt;
  logic [AW-1:0] mem_addr_nxt;
  logic [31:0]   mem_wdata_nxt;
  logic [31:0]   if_rdata_nxt, dm_rdata_nxt;
  logic          if_valid_r, if_valid_nxt;
  logic          dm_valid_nxt, err_nxt;

  logic          ack;
  logic          if_live;
  logic          starved;
  logic          win_dm, win_if;
  logic          grant_dm, grant_if;
  logic          timed_out;

  // A flush in the valid cycle itself kills the pulse, so the registered
  // valid is masked combinationally.
  assign if_valid = if_valid_r & ~if_flush;

  assign if_stall = if_req & ~if_valid & ~if_flush;
  assign dm_stall = dm_req & ~dm_valid;

  // An ack with no request outstanding is meaningless and is dropped.
  assign ack = mem_ack & mem_req;

  // Arbitration picks a winner from the raw requests first and only then
  // refuses the grant if the winner is in its own valid cycle. This way the
  // valid cycle of the favoured requester is an empty slot rather than a free
  // grant for the other side, so the DM/IF ratio set by the starvation
  // counter holds for back-to-back traffic, and no requester is granted twice
  // for the same held request.
  assign if_live  = if_req & ~if_flush;
  assign starved  = (starve_cnt == SW'(STARVE_MAX));
  assign win_dm   = dm_req & (~if_live | ~starved);
  assign win_if   = if_live & ~win_dm;
  assign grant_dm = win_dm & ~dm_valid;
  assign grant_if = win_if & ~if_valid;

  assign to_inc    = to_cnt + 1'b1;
  assign timed_out = (to_inc == TW'(TIMEOUT));

  // Next-state and next-output logic for the arbiter FSM.
  always_comb begin
    state_nxt      = state;
    starve_nxt     = starve_cnt;
    to_nxt         = to_cnt;
    flush_pend_nxt = flush_pend;
    mem_req_nxt    = mem_req;
    mem_we_nxt     = mem_we;
    mem_addr_nxt   = mem_addr;
    mem_wdata_nxt  = mem_wdata;
    if_rdata_nxt   = if_rdata;
    dm_rdata_nxt   = dm_rdata;
    if_valid_nxt   = 1'b0;
    dm_valid_nxt   = 1'b0;
    err_nxt        = 1'b0;

    // IF not waiting means nobody is being starved.
    if (!if_req) begin
      starve_nxt = '0;
    end

    case (state)
      IDLE: begin
        flush_pend_nxt = 1'b0;
        if (grant_dm) begin
          state_nxt     = DM_BUSY;
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = dm_we;
          mem_addr_nxt  = dm_addr;
          mem_wdata_nxt = dm_wdata;
          to_nxt        = '0;
          if (if_req && !starved) begin
            starve_nxt = starve_cnt + 1'b1;
          end
        end else if (grant_if) begin
          state_nxt     = IF_BUSY;
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = 1'b0;
          mem_addr_nxt  = if_addr;
          mem_wdata_nxt = '0;
          to_nxt        = '0;
          starve_nxt    = '0;
        end
      end

      IF_BUSY: begin
        if (if_flush) begin
          flush_pend_nxt = 1'b1;
        end
        if (ack) begin
          // The access always retires; only the delivery to IF is cancelled.
          state_nxt      = IDLE;
          mem_req_nxt    = 1'b0;
          flush_pend_nxt = 1'b0;
          if (!flush_pend && !if_flush) begin
            if_rdata_nxt = mem_rdata;
            if_valid_nxt = 1'b1;
          end
        end else if (timed_out) begin
          state_nxt      = IDLE;
          mem_req_nxt    = 1'b0;
          flush_pend_nxt = 1'b0;
          err_nxt        = 1'b1;
          to_nxt         = '0;
        end else begin
          to_nxt = to_inc;
        end
      end

      DM_BUSY: begin
        if (ack) begin
          state_nxt    = IDLE;
          mem_req_nxt  = 1'b0;
          dm_rdata_nxt = mem_rdata;
          dm_valid_nxt = 1'b1;
        end else if (timed_out) begin
          state_nxt   = IDLE;
          mem_req_nxt = 1'b0;
          err_nxt     = 1'b1;
          to_nxt      = '0;
        end else begin
          to_nxt = to_inc;
        end
      end

      default: begin
        state_nxt   = IDLE;
        mem_req_nxt = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset drops any in-flight access silently.
  always_ff @(posedge clock1 or posedge reset1) begin
    if (reset1) begin
      state      <= IDLE;
      starve_cnt <= '0;
      to_cnt     <= '0;
      flush_pend <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      if_valid_r <= 1'b0;
      dm_valid   <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      to_cnt     <= to_nxt;
      flush_pend <= flush_pend_nxt;
      mem_req    <= mem_req_nxt;
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      if_rdata   <= if_rdata_nxt;
      dm_rdata   <= dm_rdata_nxt;
      if_valid_r <= if_valid_nxt;
      dm_valid   <= dm_valid_nxt;
      err        <= err_nxt;
    end
  end

endmodule

// File: tb/tb_dlx_mem_arbiter.sv
// Purpose: directed scoreboard bench for dlx_mem_arbiter with a latency-programmable memory model.
// Latency: expected transactions are queued up front; the monitor checks each one as mem_req rises and falls.
// Backpressure: requesters hold req until their valid; every wait is bounded by a cycle budget.
module tb_dlx_mem_arbiter;

  logic        clock1;
  logic        reset1;
  logic        if_req, if_flush, if_valid, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_valid, dm_stall;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_req, mem_we, mem_ack, err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  dlx_mem_arbiter #(.AW(32), .STARVE_MAX(2), .TIMEOUT(15)) dut (
    .clock1(clock1), .reset1(reset1),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
  );

  initial begin
    clock1 = 1'b0;
    forever #5 clock1 = ~clock1;
  end

  // outc bits: {if_valid, dm_valid, err} expected in the cycle after mem_req falls.
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          len;    // cycles mem_req stays high; -1 = not checked
    logic [2:0]  outc;
    logic [31:0] data;
  } txn_t;

  txn_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   ifv_seen = 0;
  int   dmv_seen = 0;
  int   err_seen = 0;
  int   ack_lat = 1;     // 0 = never acknowledge
  logic late_ack = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    if (a == 32'h10) return 32'h2001_0005;
    return 32'h1000_0000 | a;
  endfunction

  function automatic txn_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input int len, input logic [2:0] outc, input logic [31:0] data);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wdata; t.len = len; t.outc = outc; t.data = data;
    return t;
  endfunction

  function automatic logic sel_sig(input int which);
    case (which)
      0:       return if_valid;
      1:       return dm_valid;
      2:       return err;
      default: return mem_req;
    endcase
  endfunction

  // Waits on negedges until the selected output is high; cyc = negedges taken.
  task automatic wait_sig(input int which, input int budget, output int cyc);
    bit done;
    done = 0;
    cyc = 0;
    while (!done) begin
      @(negedge clock1);
      cyc++;
      if (sel_sig(which)) done = 1;
      else if (cyc >= budget) begin
        n_total++;
        $display("FAIL wait_%0d: no event within %0d cycles", which, budget);
        done = 1;
      end
    end
  endtask

  // Memory model: ack in the ack_lat-th cycle that mem_req is high.
  initial begin
    int cnt;
    cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clock1);
      #1;
      if (mem_req) cnt++;
      else cnt = 0;
      mem_ack = late_ack | (mem_req && ack_lat != 0 && cnt == ack_lat);
      mem_rdata = mem_ack ? rdata_of(mem_addr) : 32'h0;
    end
  end

  // Monitor: pops one expected transaction per mem_req rise, checks it while
  // high and checks the completion outcome in the cycle after it falls.
  logic       prev_req = 1'b0;
  int         hi_cnt = 0;
  bit         have_cur = 0;
  txn_t       cur;
  logic [2:0] outb;

  initial begin
    forever begin
      @(negedge clock1);
      outb = {if_valid, dm_valid, err};
      if (if_valid) ifv_seen++;
      if (dm_valid) dmv_seen++;
      if (err) err_seen++;
      if (mem_req && !prev_req) begin
        hi_cnt = 0;
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL grant_unexpected: addr %0h with no expected grant", mem_addr);
          have_cur = 0;
        end else begin
          cur = exp_q.pop_front();
          have_cur = 1;
        end
      end
      if (mem_req && have_cur) begin
        hi_cnt++;
        chk("grant_we", {31'd0, mem_we}, {31'd0, cur.we});
        chk("grant_addr", mem_addr, cur.addr);
        if (cur.we) chk("grant_wdata", mem_wdata, cur.wdata);
      end
      if (!mem_req && prev_req && have_cur) begin
        chk("outcome", {29'd0, outb}, {29'd0, cur.outc});
        if (cur.len > 0) chk("req_len", hi_cnt, cur.len);
        if (if_valid) chk("if_rdata", if_rdata, cur.data);
        if (dm_valid && !cur.we) chk("dm_rdata", dm_rdata, cur.data);
        have_cur = 0;
      end else if (outb != 3'b000) begin
        chk("unexpected_pulse", {29'd0, outb}, 32'd0);
      end
      prev_req = mem_req;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_ctl"}, {26'd0, mem_req, mem_we, if_valid, dm_valid, err, 1'b0}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_if_rdata"}, if_rdata, 32'd0);
    chk({tag, "_dm_rdata"}, dm_rdata, 32'd0);
  endtask

  initial begin
    int c;
    reset1 = 1'b1;
    if_req = 0; if_addr = '0; if_flush = 0;
    dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
    #3;
    check_outputs_zero("reset");
    repeat (2) @(negedge clock1);
    reset1 = 1'b0;
    @(negedge clock1);

    // 1: fetch only, ack latency 1
    ack_lat = 1;
    exp_q.push_back(mk(1'b0, 32'h10, 32'h0, 1, 3'b100, 32'h2001_0005));
    if_addr = 32'h10; if_req = 1;
    #1 chk("t1_stall_req", {31'd0, if_stall}, 32'd1);
    @(negedge clock1);
    chk("t1_stall_busy", {31'd0, if_stall}, 32'd1);
    @(negedge clock1);
    chk("t1_valid_at_2", {31'd0, if_valid}, 32'd1);
    chk("t1_stall_valid", {31'd0, if_stall}, 32'd0);
    if_req = 0;
    repeat (2) @(negedge clock1);

    // 2: IF held against four back-to-back loads; order DM, DM, IF, DM, DM
    exp_q.push_back(mk(1'b0, 32'h200, 32'h0, 1, 3'b010, 32'h1000_0200));
    exp_q.push_back(mk(1'b0, 32'h204, 32'h0, 1, 3'b010, 32'h1000_0204));
    exp_q.push_back(mk(1'b0, 32'h100, 32'h0, 1, 3'b100, 32'h1000_0100));
    exp_q.push_back(mk(1'b0, 32'h208, 32'h0, 1, 3'b010, 32'h1000_0208));
    exp_q.push_back(mk(1'b0, 32'h20c, 32'h0, 1, 3'b010, 32'h1000_020c));
    fork
      begin
        int ci;
        if_addr = 32'h100; if_req = 1;
        wait_sig(0, 60, ci);
        if_req = 0;
      end
      begin
        int cd;
        for (int k = 0; k < 4; k++) begin
          dm_addr = 32'(32'h200 + 4 * k); dm_we = 0; dm_req = 1;
          wait_sig(1, 40, cd);
        end
        dm_req = 0;
      end
    join
    repeat (2) @(negedge clock1);

    // 3: store, ack latency 3
    ack_lat = 3;
    exp_q.push_back(mk(1'b1, 32'h40, 32'hDEAD_BEEF, 3, 3'b010, 32'h0));
    dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF; dm_we = 1; dm_req = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock1);
      chk("t3_dm_stall_busy", {31'd0, dm_stall}, 32'd1);
    end
    @(negedge clock1);
    chk("t3_dm_valid", {31'd0, dm_valid}, 32'd1);
    chk("t3_dm_stall_valid", {31'd0, dm_stall}, 32'd0);
    dm_req = 0; dm_we = 0;
    repeat (2) @(negedge clock1);

    // 4: flush one cycle before the ack; redirected fetch granted next
    exp_q.push_back(mk(1'b0, 32'h20, 32'h0, 3, 3'b000, 32'h0));
    exp_q.push_back(mk(1'b0, 32'h24, 32'h0, 3, 3'b100, 32'h1000_0024));
    if_addr = 32'h20; if_req = 1;
    repeat (2) @(negedge clock1);
    if_flush = 1; if_addr = 32'h24;
    @(negedge clock1);
    if_flush = 0;
    @(negedge clock1);
    chk("t4_rdata_kept", if_rdata, 32'h1000_0100);
    chk("t4_no_valid", {31'd0, if_valid}, 32'd0);
    wait_sig(0, 20, c);
    if_req = 0;
    repeat (2) @(negedge clock1);

    // 5: no ack -> abort after 15 cycles, err, then the held request is regranted
    ack_lat = 0;
    exp_q.push_back(mk(1'b0, 32'h300, 32'h0, 15, 3'b001, 32'h0));
    exp_q.push_back(mk(1'b0, 32'h300, 32'h0, 2, 3'b010, 32'h1000_0300));
    dm_addr = 32'h300; dm_we = 0; dm_req = 1;
    wait_sig(2, 40, c);
    chk("t5_err_cycle", c, 32'd16);
    ack_lat = 2;
    wait_sig(1, 20, c);
    chk("t5_regrant_valid_cycle", c, 32'd3);
    dm_req = 0;
    repeat (2) @(negedge clock1);

    // 6: reset between edges during DM_BUSY, then a stray ack
    ack_lat = 0;
    exp_q.push_back(mk(1'b0, 32'h400, 32'h0, -1, 3'b000, 32'h0));
    dm_addr = 32'h400; dm_req = 1;
    wait_sig(3, 10, c);
    #2 reset1 = 1; dm_req = 0;
    #1 check_outputs_zero("t6_reset");
    @(negedge clock1);
    reset1 = 0;
    late_ack = 1;
    @(negedge clock1);
    late_ack = 0;
    repeat (4) @(negedge clock1);
    chk("t6_mem_req_idle", {31'd0, mem_req}, 32'd0);

    chk("queue_drained", exp_q.size(), 32'd0);
    chk("if_valid_count", ifv_seen, 32'd3);
    chk("dm_valid_count", dmv_seen, 32'd6);
    chk("err_count", err_seen, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
